// File: rtl/lbist_session_ctrl.sv
// lbist_session_ctrl: logic-BIST session engine pairing an LFSR pattern generator with a MISR compactor
// Optional feature macro: LBIST_RESP_MASK_EN (adds resp_mask, zeroes masked response bits before folding)
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle session start, sampled only in IDLE
//   seed, num_patterns    LFSR seed and pattern count (0 = one full LFSR period), latched on start
//   golden                expected signature, latched on start
//   pattern_out/valid     LFSR pattern to the circuit under test, valid during RUN
//   resp_in               same-cycle response folded into the MISR
//   busy, done            session in progress, one-cycle end pulse
//   pass, seed_err        signature match result, zero-seed flag
//   signature             MISR contents, pattern_count patterns compacted
module lbist_session_ctrl #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] LFSR_TAPS = 4'b1100,
   parameter logic [WIDTH-1:0] MISR_TAPS = 4'b1100,
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic [WIDTH-1:0] golden,
`ifdef LBIST_RESP_MASK_EN
   input  logic [WIDTH-1:0] resp_mask,
`endif
   output logic [WIDTH-1:0] pattern_out,
   output logic             pattern_valid,
   input  logic [WIDTH-1:0] resp_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             seed_err,
   output logic [WIDTH-1:0] signature,
   output logic [CNT_W-1:0] pattern_count
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] lfsr, misr, seed_q, golden_q, lfsr_nx, misr_nx, resp_eff;
   logic [CNT_W-1:0] cnt, num_q, cnt_inc;
   logic pass_q, sig_ok, term;
`ifdef LBIST_RESP_MASK_EN
   logic [WIDTH-1:0] mask_q;
   assign resp_eff = resp_in & ~mask_q;
`else
   assign resp_eff = resp_in;
`endif
   assign lfsr_nx = {lfsr[WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
   assign misr_nx = {misr[WIDTH-2:0], ^(misr & MISR_TAPS)} ^ resp_eff;
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
   // full-period mode stops when the next pattern would repeat the seed
   assign term    = (num_q != '0) ? (cnt_inc == num_q) : (lfsr_nx == seed_q);
   assign sig_ok  = (misr == golden_q) && !seed_err;
   assign pattern_out   = lfsr;
   assign signature     = misr;
   assign pattern_count = cnt;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_comb begin
      state_nx      = state;
      pattern_valid = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      pass          = pass_q;
      state_nx      = (state == IDLE) ? (start ? ((seed != '0) ? RUN : DONE) : IDLE) :
                      (state == RUN)  ? (term ? DONE : RUN) : IDLE;
      pattern_valid = (state == RUN);
      busy          = (state != IDLE);
      done          = (state == DONE);
      // the final signature is settled by the DONE cycle, so pass is shown live there and held after
      pass          = (state == DONE) ? sig_ok : pass_q;
   end
   always_ff @(posedge clk)
      if (rst) begin
         lfsr     <= '0;
         misr     <= '0;
         cnt      <= '0;
         seed_q   <= '0;
         num_q    <= '0;
         golden_q <= '0;
         pass_q   <= 1'b0;
         seed_err <= 1'b0;
`ifdef LBIST_RESP_MASK_EN
         mask_q   <= '0;
`endif
      end else begin
         if (state == IDLE && start) begin
            seed_err <= (seed == '0);
            pass_q   <= 1'b0;
            if (seed != '0) begin
               lfsr     <= seed;
               misr     <= '0;
               cnt      <= '0;
               seed_q   <= seed;
               num_q    <= num_patterns;
               golden_q <= golden;
`ifdef LBIST_RESP_MASK_EN
               mask_q   <= resp_mask;
`endif
            end
         end
         if (state == RUN) begin
            lfsr <= lfsr_nx;
            misr <= misr_nx;
            cnt  <= cnt_inc;
         end
         if (state == DONE) pass_q <= sig_ok;
      end
endmodule

// File: tb/tb_lbist_session_ctrl.sv
// tb_lbist_session_ctrl: randomized self-checking bench for lbist_session_ctrl against a session-level model
module tb_lbist_session_ctrl;
   localparam int W = 4;
   localparam int LT = 12;
   localparam int MT = 12;
`ifdef LBIST_RESP_MASK_EN
   localparam bit MASK_ON = 1'b1;
`else
   localparam bit MASK_ON = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] seed = '0, golden = '0, resp_in = '0, resp_mask = '0;
   logic [15:0] num_patterns = '0;
   logic [W-1:0] pattern_out, signature;
   logic pattern_valid, busy, done, pass, seed_err;
   logic [15:0] pattern_count;
   int n_checks = 0, n_fail = 0;

   lbist_session_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .num_patterns(num_patterns), .golden(golden),
`ifdef LBIST_RESP_MASK_EN
      .resp_mask(resp_mask),
`endif
      .pattern_out(pattern_out), .pattern_valid(pattern_valid), .resp_in(resp_in), .busy(busy),
      .done(done), .pass(pass), .seed_err(seed_err), .signature(signature), .pattern_count(pattern_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] m_lfsr(input logic [W-1:0] x);
      int v;
      v = (int'(x) * 2) % (1 << W) + ($countones(int'(x) & LT) % 2);
      return W'(v);
   endfunction

   function automatic logic [W-1:0] m_misr(input logic [W-1:0] x, input logic [W-1:0] r);
      int v;
      v = (int'(x) * 2) % (1 << W) + ($countones(int'(x) & MT) % 2);
      return W'(v) ^ r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // gmode: 0 golden = model signature, 1 random, 2 given; rmode: 0 random, 1 loopback, 2 zero
   task automatic run_session(input logic [W-1:0] sd, input int num, input int gmode, input logic [W-1:0] g_in,
                              input int rmode, input logic [W-1:0] mask, input bit poke);
      logic [W-1:0] pats[$];
      logic [W-1:0] resps[$];
      logic [W-1:0] l, m, g, r, eff_mask;
      int n;
      eff_mask = MASK_ON ? mask : '0;
      l = sd;
      do begin
         pats.push_back(l);
         l = m_lfsr(l);
      end while ((num != 0) ? (pats.size() < num) : (l != sd));
      n = pats.size();
      m = '0;
      foreach (pats[i]) begin
         r = (rmode == 0) ? W'($urandom) : (rmode == 1) ? pats[i] : '0;
         resps.push_back(r);
         m = m_misr(m, r & ~eff_mask);
      end
      g = (gmode == 0) ? m : (gmode == 1) ? W'($urandom) : g_in;
      start = 1'b1; seed = sd; num_patterns = 16'(num); golden = g; resp_mask = mask;
      cyc();
      start = 1'b0;
      m = '0;
      for (int i = 0; i < n; i++) begin
         check("run_valid", 32'(pattern_valid), 1);
         check("run_pattern", 32'(pattern_out), 32'(pats[i]));
         check("run_sig", 32'(signature), 32'(m));
         check("run_busy_done", {busy, done}, 32'b10);
         if (i == 0) check("start_clears", {seed_err, pass}, 0);
         resp_in = resps[i];
         m = m_misr(m, resps[i] & ~eff_mask);
         start = poke && (i == 1);
         seed = W'($urandom_range(1, 15));
         cyc();
         start = 1'b0;
      end
      check("done_pulse", {done, busy, pattern_valid}, 32'b110);
      check("done_pass", 32'(pass), 32'(m == g));
      check("done_sig", 32'(signature), 32'(m));
      check("done_count", 32'(pattern_count), 32'(n));
      start = poke;
      cyc();
      start = 1'b0;
      check("idle_flags", {done, busy, pattern_valid}, 0);
      check("idle_pass_hold", 32'(pass), 32'(m == g));
      check("idle_sig_hold", 32'(signature), 32'(m));
      check("idle_pattern_hold", 32'(pattern_out), 32'(l));
      check("idle_count_hold", 32'(pattern_count), 32'(n));
   endtask

   task automatic seed_zero();
      start = 1'b1; seed = '0; num_patterns = 16'd5; golden = '0;
      cyc();
      start = 1'b0;
      check("sz_done", {done, busy, pattern_valid}, 32'b110);
      check("sz_err_pass", {seed_err, pass}, 32'b10);
      cyc();
      check("sz_idle", {done, busy, pattern_valid}, 0);
      check("sz_err_hold", {seed_err, pass}, 32'b10);
   endtask

   task automatic reset_mid_run();
      start = 1'b1; seed = 4'h1; num_patterns = 16'd10; golden = '0; resp_in = '0;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         resp_in = W'($urandom);
         cyc();
      end
      check("rst_pre_busy", 32'(busy), 1);
      rst = 1'b1;
      cyc();
      check("rst_outs", {pattern_out, pattern_valid, busy, done, pass, seed_err, signature, pattern_count}, 0);
      rst = 1'b0;
      cyc();
      check("rst_no_done", {done, busy, pattern_valid}, 0);
   endtask

   initial begin
      cyc();
      cyc();
      check("reset_outs", {pattern_out, pattern_valid, busy, done, pass, seed_err, signature}, 0);
      check("reset_count", 32'(pattern_count), 0);
      rst = 1'b0;
      cyc();
      run_session(4'h1, 0, 2, 4'h0, 2, 4'h0, 1'b0);
      run_session(4'h1, 3, 2, 4'h4, 1, 4'h0, 1'b0);
      run_session(4'h1, 3, 2, 4'h5, 1, 4'h0, 1'b0);
      seed_zero();
      run_session(4'h9, 6, 0, 4'h0, 0, 4'h0, 1'b1);
      run_session(4'h3, 4, 1, 4'h0, 0, 4'h0, 1'b1);
      if (MASK_ON) run_session(4'h1, 0, 2, 4'h0, 1, 4'hF, 1'b0);
      reset_mid_run();
      for (int k = 0; k < 25; k++) begin
         if ($urandom_range(0, 7) == 0) seed_zero();
         run_session(W'($urandom_range(1, 15)), int'($urandom_range(0, 20)), int'($urandom_range(0, 1)), 4'h0,
                     int'($urandom_range(0, 2)), W'($urandom), 1'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
